// File: rtl/usr_ctrl_if.sv
// Command/status bundle between a command source and the usr_ctrl sequencer.
// USR_ROTATE_EN adds the rotate flag and register end-bit feedback.
interface usr_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_sin;
  logic [1:0]       sel;
  logic             sin_r;
  logic             sin_l;
  logic             busy;
  logic             done;
`ifdef USR_ROTATE_EN
  logic             cmd_rot;
  logic             q_msb;
  logic             q_lsb;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_sin, cmd_rot, q_msb, q_lsb,
    input  cmd_ready, sel, sin_r, sin_l, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_sin, cmd_rot, q_msb, q_lsb,
    output cmd_ready, sel, sin_r, sin_l, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_sin,
    input  cmd_ready, sel, sin_r, sin_l, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_sin,
    output cmd_ready, sel, sin_r, sin_l, busy, done
  );
`endif
endinterface

// File: rtl/usr_ctrl.sv
// Command sequencer for the universal shift register: drives mux select and serial-in bits.
// Optional USR_ROTATE_EN feeds the register end bits back as serial input for rotates.
module usr_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  usr_ctrl_if.slave  bus
);

  localparam logic [1:0] OP_WAIT = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       sel_q, sel_n;
  logic             sin_r_q, sin_r_n;
  logic             sin_l_q, sin_l_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             accept;
`ifdef USR_ROTATE_EN
  logic             rot_q, rot_n;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign accept        = bus.cmd_valid && (state_q == IDLE);

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= OP_WAIT;
      sin_r_q <= 1'b0;
      sin_l_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef USR_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sel_q   <= sel_n;
      sin_r_q <= sin_r_n;
      sin_l_q <= sin_l_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
`ifdef USR_ROTATE_EN
      rot_q   <= rot_n;
`endif
    end
  end

  // Next state, down-counter and next output values
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sel_n   = sel_q;
    sin_r_n = sin_r_q;
    sin_l_n = sin_l_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
`ifdef USR_ROTATE_EN
    rot_n   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          busy_n = 1'b1;
`ifdef USR_ROTATE_EN
          rot_n  = bus.cmd_rot;
`endif
          if (bus.cmd_op == OP_LOAD) begin
            state_n = ACTIVE;
            cnt_n   = CNT_W'(1);
            sel_n   = OP_LOAD;
            sin_r_n = 1'b0;
            sin_l_n = 1'b0;
          end else if (bus.cmd_cnt == '0) begin
            // Zero-length shift/wait completes without ever leaving hold
            state_n = DONE;
            done_n  = 1'b1;
            cnt_n   = '0;
            sel_n   = OP_WAIT;
            sin_r_n = 1'b0;
            sin_l_n = 1'b0;
          end else begin
            state_n = ACTIVE;
            cnt_n   = bus.cmd_cnt;
            sel_n   = bus.cmd_op;
            sin_r_n = (bus.cmd_op == OP_SHR) && bus.cmd_sin;
            sin_l_n = (bus.cmd_op == OP_SHL) && bus.cmd_sin;
          end
        end
      end
      ACTIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          cnt_n   = '0;
          sel_n   = OP_WAIT;
          sin_r_n = 1'b0;
          sin_l_n = 1'b0;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        sel_n   = OP_WAIT;
        sin_r_n = 1'b0;
        sin_l_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
        sel_n   = OP_WAIT;
        sin_r_n = 1'b0;
        sin_l_n = 1'b0;
      end
    endcase
  end

  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef USR_ROTATE_EN
  // Rotate passes the opposite end bit straight through so it tracks the register each cycle
  assign bus.sin_r = (rot_q && (state_q == ACTIVE) && (sel_q == OP_SHR)) ? bus.q_lsb : sin_r_q;
  assign bus.sin_l = (rot_q && (state_q == ACTIVE) && (sel_q == OP_SHL)) ? bus.q_msb : sin_l_q;
`else
  assign bus.sin_r = sin_r_q;
  assign bus.sin_l = sin_l_q;
`endif

endmodule

// File: doc/usr_ctrl.md
# usr_ctrl

Command sequencer for the universal shift register datapath. It accepts shift/load commands over a valid/ready handshake. It drives the registered 2-bit mode select `sel` that fans out to every per-bit 4:1 mux, plus the serial-in bits presented on mux inputs x1/x2. It holds each mode for the commanded number of cycles, then pulses `done`.

## Interface
- `CNT_W`, default 4: width of the shift-count field; max count is 2^CNT_W-1.
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  asynchronous reset, active-low.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  sequencer can accept a command.
- `cmd_op`  input  2  00 wait, 01 shift right, 10 shift left, 11 parallel load.
- `cmd_cnt`  input  CNT_W  cycles to apply op; ignored for load.
- `cmd_sin`  input  1  serial bit shifted in during a shift command.
- `sel`  output  2  mux select: 00 hold, 01 SHR, 10 SHL, 11 load.
- `sin_r`  output  1  serial input into the MSB for SHR (mux x1 of the MSB).
- `sin_l`  output  1  serial input into the LSB for SHL (mux x2 of the LSB).
- `busy`  output  1  high whenever state is not IDLE.
- `done`  output  1  one-cycle pulse at command completion.

## Operation
- States: IDLE, ACTIVE, DONE.
  - IDLE: `cmd_ready`=1, `sel`=00.
  - ACTIVE: `sel`=latched op; down-counter decrements each cycle.
  - DONE: `sel`=00, `done`=1, `cmd_ready`=0.
- Accept occurs when `cmd_valid`&`cmd_ready` is sampled at a rising edge. On accept, op, cnt and sin are latched; `cmd_*` are don't-care afterwards.
- IDLE transitions on accept:
  - op 01/10/00 with cnt>0 → ACTIVE for exactly cnt cycles.
  - op 11 → ACTIVE for exactly 1 cycle (cnt forced to 1).
  - cnt=0 with op≠11 → directly DONE; `sel` never leaves 00.
- ACTIVE → DONE when the remaining count reaches 1 at an edge. DONE → IDLE unconditionally.
- Op 00 with cnt>0 is a timed hold: `sel`=00 throughout, `busy`=1.
- `sin_r`: latched sin during ACTIVE with op 01, else 0. `sin_l`: latched sin during ACTIVE with op 10, else 0.
- `cmd_valid` asserted while not ready is ignored. The command is not queued; the source must hold it until `cmd_ready`.
- All outputs are registered except `cmd_ready`, which is decoded from state.
- Reset (asynchronous, any time including mid-ACTIVE) forces:
  - state IDLE, counter 0, `sel`=00, `sin_r`=0, `sin_l`=0, `busy`=0, `done`=0, `cmd_ready`=1.
  - The aborted command produces no `done`.

## Timing
- Accept at edge k (cnt=N≥1 shift/wait):
  - `sel`=op during cycles k+1 … k+N.
  - `done`=1 and `sel`=00 in cycle k+N+1.
  - `cmd_ready`=1 again in cycle k+N+2.
- Load: `sel`=11 in cycle k+1, `done` in k+2, ready in k+3.
- cnt=0: `done` in k+1, ready in k+2.
- The earliest next accept is edge k+N+2, so sustained throughput is one command per N+2 cycles.
- `busy` is high exactly in cycles k+1 … k+N+1.
- Downstream flops sample `sel`/`sin_*` at the edge ending each cycle, giving exactly N shifts for count N.

## Configuration
- `USR_ROTATE_EN` defined:
  - Adds inputs `cmd_rot` (1), `q_msb` (1) and `q_lsb` (1).
  - `cmd_rot` is latched on accept.
  - During ACTIVE SHR with rot=1, `sin_r` = `q_lsb`, passed combinationally. During ACTIVE SHL with rot=1, `sin_l` = `q_msb`.
  - With rot=0, behaviour matches the undefined case.
- Undefined: the three ports are absent, and `sin_r`/`sin_l` come only from the latched `cmd_sin`.

## Test plan
- Reset release → `sel`=00, `cmd_ready`=1, `busy`=0, `done`=0. Accept SHR cnt=3 sin=1 at edge k → `sel`=01 and `sin_r`=1 in k+1..k+3; `done` in k+4 only; ready in k+5.
- LOAD with cnt=9 → exactly one cycle of `sel`=11, then `done`; the count is ignored.
- SHL cnt=0 → `sel` stays 00, `done` at k+1. Wait op cnt=5 → `busy` for 6 cycles, `sel`=00 throughout.
- `cmd_valid` held high with a different command during ACTIVE → ignored. The second command is accepted only at k+N+2 and starts at k+N+3.
- `rst_n` low at cycle k+2 of SHL cnt=8 → outputs reset immediately (asynchronous), no `done`; a fresh command is accepted after release.
- `USR_ROTATE_EN`: SHR cnt=4 rot=1 with `q_lsb` toggling → `sin_r` tracks `q_lsb` each active cycle. With rot=0 → `sin_r`=latched `cmd_sin`.
